// File: rtl/simple_risc_pkg.sv
// rtl/simple_risc_pkg.sv - shared SimpleRISC constants and fetch-stage state encoding
package simple_risc_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h6800_0000;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SQUASH,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry data+valid holding register with load/clear/unload
module if_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         unload,
  input  logic [W-1:0] dataIn,
  output logic [W-1:0] dataOut,
  output logic         valid
);

  // clear beats load so a redirect always wins over a coincident capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      dataOut <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      dataOut <= dataIn;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - SimpleRISC IF stage: PC, imem request FSM and IF/OF latch
module if_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = simple_risc_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isBranchTaken,
  input  logic [ADDR_W-1:0] branchPC,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid
);
  import simple_risc_pkg::*;

  fetch_state_t              state;
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W-1:0]         pcNext;
  logic [ADDR_W-1:0]         target;
  logic                      done;
  logic                      inFlight;
  logic                      skidLoad;
  logic                      skidUnload;
  logic                      skidValid;
  logic [ADDR_W+DATA_W-1:0]  skidData;

  assign done     = imem_req & imem_ready;
  assign inFlight = imem_req & ~imem_ready;
  assign target   = {branchPC[ADDR_W-1:2], 2'b00};
  assign pcNext   = pc + ADDR_W'(INSTR_BYTES);

  assign skidLoad   = (state == S_REQ) && done && stall && !isBranchTaken;
  assign skidUnload = (state == S_HOLD) && !stall && !isBranchTaken;

  if_skid_buf #(.W(ADDR_W + DATA_W)) skidBuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skidLoad),
    .clear   (isBranchTaken),
    .unload  (skidUnload),
    .dataIn  ({pc, imem_rdata}),
    .dataOut (skidData),
    .valid   (skidValid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_pc     <= RESET_PC;
      if_instr  <= NOP_INSTR;
    end else if (isBranchTaken) begin
      // an in-flight fetch must still complete before the target can be requested
      pc       <= target;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      imem_req <= 1'b1;
      if (inFlight) begin
        state <= S_SQUASH;
      end else begin
        state     <= S_REQ;
        imem_addr <= target;
      end
    end else begin
      // OF consumed the latch; becomes a bubble unless something new lands below
      if (!stall) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
      case (state)
        S_IDLE: begin
          state     <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        S_REQ: begin
          if (done) begin
            pc <= pcNext;
            if (stall) begin
              imem_req <= 1'b0;
              state    <= S_HOLD;
            end else begin
              if_instr  <= imem_rdata;
              if_pc     <= pc;
              if_valid  <= 1'b1;
              imem_addr <= pcNext;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            {if_pc, if_instr} <= skidData;
            if_valid          <= skidValid;
            imem_req          <= 1'b1;
            imem_addr         <= pc;
            state             <= S_REQ;
          end
        end
        S_SQUASH: begin
          if (done) begin
            imem_addr <= pc;
            state     <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h6800_0000;

  logic        clk;
  logic        rst_n;
  logic        isBranchTaken;
  logic [31:0] branchPC;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .isBranchTaken (isBranchTaken),
    .branchPC      (branchPC),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_valid      (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          readyPct = 100;
  logic [31:0] expQ[$];
  logic [31:0] nextPush;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // program order from a start address; refilled as the stream is consumed
  task automatic topUp();
    while (expQ.size() < 64) begin
      expQ.push_back(nextPush);
      nextPush = nextPush + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    expQ.delete();
    nextPush = a;
    topUp();
  endtask

  task automatic setReady(input logic r);
    imem_ready = r;
    imem_rdata = r ? memf(imem_addr) : $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    isBranchTaken = 1'b0;
    setReady(imem_req && ($urandom_range(99) < readyPct));
    topUp();
  endtask

  task automatic branch(input logic [31:0] t);
    isBranchTaken = 1'b1;
    branchPC      = t;
    restart({t[31:2], 2'b00});
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, RST_PC);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_pc"},    if_pc, RST_PC);
    chk({tag, "_instr"}, if_instr, NOP);
  endtask

  // monitor: OF accepts the latch on an edge with if_valid, no stall and no redirect
  initial begin
    logic        prevWait;
    logic [31:0] prevAddr;
    logic [31:0] e;
    prevWait = 1'b0;
    prevAddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevWait = 1'b0;
      end else begin
        if (!if_valid) chk("bubble_nop", if_instr, NOP);
        if (prevWait) begin
          chk("addr_stable_req", {31'd0, imem_req}, 32'd1);
          chk("addr_stable", imem_addr, prevAddr);
        end
        if (imem_req && imem_addr[1:0] != 2'b00) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (if_valid && !stall && !isBranchTaken) begin
          if (expQ.size() == 0) begin
            chk("sb_underflow", if_pc, 32'hxxxx_xxxx);
          end else begin
            e = expQ.pop_front();
            chk("sb_pc", if_pc, e);
            chk("sb_instr", if_instr, memf(e));
          end
        end
        prevWait = imem_req && !imem_ready;
        prevAddr = imem_addr;
      end
    end
  end

  initial begin
    logic [31:0] frozen;
    logic [31:0] oldAddr;
    rst_n = 1'b0; isBranchTaken = 1'b0; branchPC = '0; stall = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    restart(RST_PC);
    repeat (3) @(posedge clk);
    #1;
    chkReset("reset");

    // free-running stream across the address wrap
    rst_n = 1'b1;
    restart(RST_PC);
    readyPct = 100;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stream_addr", imem_addr, RST_PC + 32'(4 * (k - 1)));
      chk("stream_valid", {31'd0, if_valid}, (k >= 2) ? 32'd1 : 32'd0);
    end

    // three-cycle stall: latch frozen, requests stop after the skid capture
    stall = 1'b1;
    frozen = if_pc;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", if_pc, frozen);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    repeat (5) step();

    // redirect with nothing in flight (held in the skid state), low target bits ignored
    stall = 1'b1;
    step();
    branch(32'h0000_2003);
    step();
    chk("br_idle_valid", {31'd0, if_valid}, 32'd0);
    chk("br_idle_req", {31'd0, imem_req}, 32'd1);
    chk("br_idle_addr", imem_addr, 32'h0000_2000);
    stall = 1'b0;
    repeat (4) step();

    // redirect while a request waits: old address kept, its data discarded
    readyPct = 0;
    step();
    oldAddr = imem_addr;
    branch(32'h0000_3000);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("sq_req", {31'd0, imem_req}, 32'd1);
      chk("sq_addr", imem_addr, oldAddr);
    end
    readyPct = 100;
    step();
    step();
    chk("sq_next_addr", imem_addr, 32'h0000_3000);
    repeat (4) step();

    // redirect coincident with a completion under stall
    stall = 1'b1;
    branch(32'h0000_4000);
    step();
    chk("br_rdy_valid", {31'd0, if_valid}, 32'd0);
    chk("br_rdy_req", {31'd0, imem_req}, 32'd1);
    chk("br_rdy_addr", imem_addr, 32'h0000_4000);
    stall = 1'b0;
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) readyPct = $urandom_range(20, 100);
      step();
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 3) branch($urandom);
    end
    stall = 1'b0;

    // reset mid-request: outputs drop at once, late ready ignored
    readyPct = 0;
    step();
    step();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chkReset("async_rst");
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    chkReset("rst_late_rdy");
    imem_ready = 1'b0;
    rst_n = 1'b1;
    restart(RST_PC);
    readyPct = 100;
    step();
    chk("rerun_req", {31'd0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, RST_PC);
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
